// File: rtl/priority_encoder_rr.sv
// Registered N-to-log2(N) priority encoder, fixed or round-robin, 1-cycle latency.
// One-entry output register; in_ready drops only while a held result is not being drained.
module priority_encoder_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  input  logic         rr_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         out_none
);

  logic [W-1:0] out_q, out_d;
  logic         out_none_q, out_none_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic         drain;
  logic         any_set;
  logic         lo_found;
  logic [W-1:0] fix_idx;
  logic [W-1:0] lo_idx;
  logic [W-1:0] hi_idx;
  logic [W-1:0] enc_idx;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;
  assign out       = out_q;
  assign out_none  = out_none_q;
  assign out_valid = out_valid_q;

  // Round-robin: highest set bit at or below ptr wins; otherwise highest set bit above ptr.
  always_comb begin
    any_set  = 1'b0;
    lo_found = 1'b0;
    fix_idx  = '0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i]) begin
        any_set = 1'b1;
        fix_idx = W'(i);
        if (i <= int'(ptr_q)) begin
          lo_found = 1'b1;
          lo_idx   = W'(i);
        end else begin
          hi_idx = W'(i);
        end
      end
    end
    if (rr_mode) begin
      enc_idx = lo_found ? lo_idx : hi_idx;
    end else begin
      enc_idx = fix_idx;
    end
  end

  always_comb begin
    out_d       = out_q;
    out_none_d  = out_none_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      if (any_set) begin
        out_d      = enc_idx;
        out_none_d = 1'b0;
        if (rr_mode) begin
          ptr_d = (enc_idx == '0) ? W'(N - 1) : enc_idx - W'(1);
        end
      end else begin
        out_none_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_none_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ptr_q       <= W'(N - 1);
    end else begin
      out_q       <= out_d;
      out_none_q  <= out_none_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

endmodule
